// File: rtl/m_imem_loader_if.sv
// Serial-in / memory-write-out bundle of the program loader.
// The loader drives the master side; the RX pin owner and m_imem observe the slave side.
interface m_imem_loader_if #(
  parameter int ADDR_W = 12
);
  logic              w_rxd;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  modport master (
    input  w_rxd,
    output r_we, r_addr, r_data, r_busy, r_done, r_err
  );

  modport slave (
    output w_rxd,
    input  r_we, r_addr, r_data, r_busy, r_done, r_err
  );
endinterface

// File: rtl/m_imem_loader.sv
// UART 8N1 program loader: 16-bit BE word count, then N big-endian words into m_imem.
// r_we fires 1 clock after the stop-bit sample of each word's 4th byte; no backpressure.
module m_imem_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 12
) (
  input  logic             w_clk,
  input  logic             w_rst,
  m_imem_loader_if.master  bus
);
  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  HALF_BIT  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0]  FULL_BIT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [31:0]       MAX_WORDS = 32'd1 << ADDR_W;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_HDR0, S_HDR1, S_DATA, S_DONE, S_ERR} ld_state_t;

  // RX synchronizer and sampler state
  logic             rxd_meta, rxd_sync, rxd_prev;
  rx_state_t        rx_state, rx_nxt;
  logic [CNT_W-1:0] rx_cnt, cnt_nxt;
  logic [2:0]       rx_bit, bit_nxt;
  logic [7:0]       rx_shift, shift_nxt;
  logic             byte_vld, frame_err, start_ok;

  // Loader state and registered outputs
  ld_state_t         ld_state, ld_nxt;
  logic [15:0]       n_words, n_nxt;
  logic [ADDR_W:0]   idx, idx_nxt;
  logic [23:0]       word_sh, word_nxt;
  logic [1:0]        bcnt, bcnt_nxt;
  logic              r_we, we_nxt;
  logic [ADDR_W-1:0] r_addr, addr_nxt;
  logic [31:0]       r_data, data_nxt;
  logic              r_busy, busy_nxt;
  logic              r_done, r_err;
  logic [15:0]       hdr_n;

  assign hdr_n = {n_words[15:8], rx_shift};

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rxd_meta <= bus.w_rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
      rx_state <= rx_nxt;
      rx_cnt   <= cnt_nxt;
      rx_bit   <= bit_nxt;
      rx_shift <= shift_nxt;
    end
  end

  // byte_vld / frame_err are combinational so the loader can act on the stop-bit sample cycle
  always_comb begin
    rx_nxt    = rx_state;
    cnt_nxt   = rx_cnt + 1'b1;
    bit_nxt   = rx_bit;
    shift_nxt = rx_shift;
    byte_vld  = 1'b0;
    frame_err = 1'b0;
    start_ok  = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        cnt_nxt = '0;
        if (rxd_prev && !rxd_sync) rx_nxt = RX_START;
      end
      RX_START: begin
        if (rx_cnt == HALF_BIT) begin
          cnt_nxt = '0;
          if (!rxd_sync) begin
            rx_nxt   = RX_DATA;
            bit_nxt  = '0;
            start_ok = 1'b1;
          end else begin
            rx_nxt = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (rx_cnt == FULL_BIT) begin
          cnt_nxt   = '0;
          shift_nxt = {rxd_sync, rx_shift[7:1]};
          bit_nxt   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt == FULL_BIT) begin
          cnt_nxt = '0;
          rx_nxt  = RX_IDLE;
          if (rxd_sync) byte_vld  = 1'b1;
          else          frame_err = 1'b1;
        end
      end
      default: rx_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      ld_state <= S_HDR0;
      n_words  <= '0;
      idx      <= '0;
      word_sh  <= '0;
      bcnt     <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      ld_state <= ld_nxt;
      n_words  <= n_nxt;
      idx      <= idx_nxt;
      word_sh  <= word_nxt;
      bcnt     <= bcnt_nxt;
      r_we     <= we_nxt;
      r_addr   <= addr_nxt;
      r_data   <= data_nxt;
      r_busy   <= busy_nxt;
      r_done   <= (ld_nxt == S_DONE);
      r_err    <= (ld_nxt == S_ERR);
    end
  end

  always_comb begin
    ld_nxt   = ld_state;
    n_nxt    = n_words;
    idx_nxt  = idx;
    word_nxt = word_sh;
    bcnt_nxt = bcnt;
    we_nxt   = 1'b0;
    addr_nxt = r_addr;
    data_nxt = r_data;
    busy_nxt = r_busy;
    case (ld_state)
      S_HDR0: begin
        if (start_ok) busy_nxt = 1'b1;
        if (frame_err) begin
          ld_nxt = S_ERR;
        end else if (byte_vld) begin
          n_nxt[15:8] = rx_shift;
          ld_nxt      = S_HDR1;
        end
      end
      S_HDR1: begin
        if (frame_err) begin
          ld_nxt = S_ERR;
        end else if (byte_vld) begin
          n_nxt[7:0] = rx_shift;
          if (hdr_n == 16'd0)                ld_nxt = S_DONE;
          else if (32'(hdr_n) > MAX_WORDS)   ld_nxt = S_ERR;
          else                               ld_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (frame_err) begin
          ld_nxt = S_ERR;
        end else if (byte_vld) begin
          if (bcnt == 2'd3) begin
            we_nxt   = 1'b1;
            addr_nxt = idx[ADDR_W-1:0];
            data_nxt = {word_sh, rx_shift};
            idx_nxt  = idx + 1'b1;
            bcnt_nxt = '0;
            if (32'(idx_nxt) == 32'(n_words)) ld_nxt = S_DONE;
          end else begin
            word_nxt = {word_sh[15:0], rx_shift};
            bcnt_nxt = bcnt + 2'd1;
          end
        end
      end
      default: ;
    endcase
    if (ld_nxt == S_DONE || ld_nxt == S_ERR) busy_nxt = 1'b0;
  end

  assign bus.r_we   = r_we;
  assign bus.r_addr = r_addr;
  assign bus.r_data = r_data;
  assign bus.r_busy = r_busy;
  assign bus.r_done = r_done;
  assign bus.r_err  = r_err;
endmodule

// File: tb/tb_m_imem_loader.sv
// Directed and randomized UART frames against a byte-level model of the loader protocol.
module tb_m_imem_loader;
  localparam int CPB    = 4;
  localparam int ADDR_W = 12;

  logic w_clk = 1'b0;
  logic w_rst = 1'b1;
  always #5 w_clk = ~w_clk;

  m_imem_loader_if #(.ADDR_W(ADDR_W)) bus ();
  m_imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W)) dut (
    .w_clk (w_clk),
    .w_rst (w_rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]        frm[$];
  logic [ADDR_W-1:0] cap_addr[$];
  logic [31:0]       cap_data[$];
  logic [ADDR_W-1:0] exp_addr[$];
  logic [31:0]       exp_data[$];
  logic              exp_done, exp_err;

  always @(negedge w_clk) begin
    if (bus.r_we) begin
      cap_addr.push_back(bus.r_addr);
      cap_data.push_back(bus.r_data);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge w_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bus.w_rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.w_rxd = b[i];
      tick(CPB);
    end
    bus.w_rxd = stop;
    tick(CPB);
    if (!stop) begin
      bus.w_rxd = 1'b1;
      tick(CPB);
    end
  endtask

  // Expected outcome of frm when byte number bad (if >= 0) has a broken stop bit
  task automatic model(input int bad);
    int n;
    exp_addr.delete();
    exp_data.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    n = 0;
    for (int i = 0; i < frm.size(); i++) begin
      if (exp_done || exp_err) continue;
      if (i == bad) begin
        exp_err = 1'b1;
        continue;
      end
      if (i == 1) begin
        n = frm[0] * 256 + frm[1];
        if (n == 0) exp_done = 1'b1;
        else if (n > (1 << ADDR_W)) exp_err = 1'b1;
      end else if (i >= 2 && (i - 2) % 4 == 3) begin
        exp_addr.push_back(ADDR_W'((i - 2) / 4));
        exp_data.push_back({frm[i-3], frm[i-2], frm[i-1], frm[i]});
        if ((i - 2) / 4 + 1 == n) exp_done = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    w_rst = 1'b1;
    tick(2);
    w_rst = 1'b0;
    tick(1);
    cap_addr.delete();
    cap_data.delete();
  endtask

  task automatic send_range(input int lo, input int hi, input int bad);
    for (int i = lo; i < hi; i++) send_byte(frm[i], i != bad);
  endtask

  task automatic compare(input string tag);
    check({tag, " write count"}, cap_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < cap_addr.size(); i++) begin
      check({tag, " addr"}, cap_addr[i], exp_addr[i]);
      check({tag, " data"}, cap_data[i], exp_data[i]);
    end
    check({tag, " r_done"}, bus.r_done, exp_done);
    check({tag, " r_err"},  bus.r_err,  exp_err);
    check({tag, " r_busy"}, bus.r_busy, 1'b0);
  endtask

  task automatic run_frame(input string tag, input int bad);
    model(bad);
    do_reset();
    send_range(0, frm.size(), bad);
    tick(5 * CPB);
    compare(tag);
  endtask

  initial begin
    int k;
    int n;
    int bad;
    bus.w_rxd = 1'b1;
    tick(3);
    w_rst = 1'b0;
    tick(1);
    check("reset r_we",   bus.r_we,   1'b0);
    check("reset r_addr", bus.r_addr, '0);
    check("reset r_data", bus.r_data, '0);
    check("reset r_busy", bus.r_busy, 1'b0);
    check("reset r_done", bus.r_done, 1'b0);
    check("reset r_err",  bus.r_err,  1'b0);

    // Two-word image, with exact write latency on the first word
    frm = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h10, 8'h00, 8'h20, 8'h09, 8'h00, 8'h00};
    model(-1);
    do_reset();
    send_range(0, 1, -1);
    check("t1 busy after first byte", bus.r_busy, 1'b1);
    send_range(1, 6, -1);
    k = 0;
    do begin
      tick(1);
      k++;
    end while (!bus.r_we && k < 10);
    check("t1 r_we latency", k, 2);
    check("t1 done before last word", bus.r_done, 1'b0);
    send_range(6, 10, -1);
    tick(5 * CPB);
    compare("t1");
    check("t1 word0 const", (cap_data.size() > 0) ? cap_data[0] : 32'hx, 32'h20081000);
    check("t1 word1 const", (cap_data.size() > 1) ? cap_data[1] : 32'hx, 32'h20090000);

    frm = '{8'h00, 8'h00};
    run_frame("t2 empty", -1);

    frm = '{8'h10, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    run_frame("t3 oversize", -1);

    frm = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_frame("t4 framing", 4);

    do_reset();
    bus.w_rxd = 1'b0;
    tick(2);
    bus.w_rxd = 1'b1;
    tick(5 * CPB);
    check("t5 glitch busy",  bus.r_busy, 1'b0);
    check("t5 glitch writes", cap_addr.size(), 0);
    check("t5 glitch done",  bus.r_done, 1'b0);
    check("t5 glitch err",   bus.r_err,  1'b0);

    // Reset after two of three words, then a full resend
    frm = '{8'h00, 8'h03};
    repeat (12) frm.push_back(8'($urandom));
    do_reset();
    send_range(0, 10, -1);
    tick(5 * CPB);
    check("t6 partial writes", cap_addr.size(), 2);
    check("t6 partial busy",   bus.r_busy, 1'b1);
    w_rst = 1'b1;
    tick(1);
    check("t6 rst r_we",   bus.r_we,   1'b0);
    check("t6 rst r_addr", bus.r_addr, '0);
    check("t6 rst r_data", bus.r_data, '0);
    check("t6 rst r_busy", bus.r_busy, 1'b0);
    check("t6 rst r_done", bus.r_done, 1'b0);
    w_rst = 1'b0;
    run_frame("t6 resend", -1);

    for (int it = 0; it < 6; it++) begin
      if (it == 5) n = $urandom_range(65535, (1 << ADDR_W) + 1);
      else         n = $urandom_range(5, 1);
      frm.delete();
      frm.push_back(8'(n >> 8));
      frm.push_back(8'(n));
      for (int j = 0; j < 4 * ((n > 5) ? 2 : n); j++) frm.push_back(8'($urandom));
      bad = -1;
      if (it == 2) bad = $urandom_range(frm.size() - 1, 2);
      if (it == 3) bad = $urandom_range(1, 0);
      run_frame($sformatf("rand%0d", it), bad);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
